// File: rtl/dsp_dot_accum.sv
// Accumulates signed partial dot-products per vector, then rounds, shifts and saturates the sum.
// Result is valid two edges after in_last; no input backpressure, an unaccepted result is overwritten (sticky overrun).
module dsp_dot_accum #(
    parameter int RESULT_A_WIDTH = 44,
    parameter int ACC_WIDTH      = 52,
    parameter int SHIFT          = 4,
    parameter int OUT_WIDTH      = 24,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic signed [RESULT_A_WIDTH-1:0] in_data,
    input  logic                             in_last,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic signed [OUT_WIDTH-1:0]      out_data,
    output logic                             out_sat,
    output logic [CNT_WIDTH-1:0]             out_len,
    output logic                             overrun
);

    localparam int AW = ACC_WIDTH;
    localparam int XW = (AW + 1 > OUT_WIDTH) ? AW + 1 : OUT_WIDTH;

    localparam logic signed [AW-1:0] ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN  = {1'b1, {(AW-1){1'b0}}};
    localparam logic        [AW:0]   RND_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0]   RND_BIAS = (RND_ONE << SHIFT) >> 1;
    localparam logic signed [XW-1:0] OUT_MAX  = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] OUT_MIN  = ~OUT_MAX;

    logic signed [AW-1:0]        acc;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        first;
    logic                        acc_ovf;
    logic                        done;

    logic signed [AW-1:0]        acc_base;
    logic signed [AW:0]          acc_sum;
    logic signed [AW-1:0]        acc_nxt;
    logic                        acc_ovf_nxt;
    logic [CNT_WIDTH-1:0]        cnt_nxt;

    // One guard bit is enough to detect overflow of a single add.
    always_comb begin
        acc_base    = first ? '0 : acc;
        acc_sum     = {acc_base[AW-1], acc_base}
                    + {{(AW+1-RESULT_A_WIDTH){in_data[RESULT_A_WIDTH-1]}}, in_data};
        acc_nxt     = acc_sum[AW-1:0];
        acc_ovf_nxt = first ? 1'b0 : acc_ovf;
        if (acc_sum[AW] != acc_sum[AW-1]) begin
            acc_nxt     = acc_sum[AW] ? ACC_MIN : ACC_MAX;
            acc_ovf_nxt = 1'b1;
        end
        if (first) begin
            cnt_nxt = CNT_WIDTH'(1);
        end else if (&cnt) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            first   <= 1'b1;
            acc_ovf <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= in_valid & in_last;
            if (in_valid) begin
                acc     <= acc_nxt;
                cnt     <= cnt_nxt;
                acc_ovf <= acc_ovf_nxt;
                first   <= in_last;
            end
        end
    end

    logic signed [AW:0]          rnd_sum;
    logic signed [AW:0]          rnd_shr;
    logic signed [XW-1:0]        rnd_ext;
    logic signed [OUT_WIDTH-1:0] rnd_out;
    logic                        rnd_clamp;

    // The finished vector sum sits in acc for exactly the cycle done is high.
    always_comb begin
        rnd_sum   = {acc[AW-1], acc} + RND_BIAS;
        rnd_shr   = rnd_sum >>> SHIFT;
        rnd_ext   = XW'(rnd_shr);
        rnd_out   = rnd_ext[OUT_WIDTH-1:0];
        rnd_clamp = 1'b0;
        if (rnd_ext > OUT_MAX) begin
            rnd_out   = OUT_MAX[OUT_WIDTH-1:0];
            rnd_clamp = 1'b1;
        end else if (rnd_ext < OUT_MIN) begin
            rnd_out   = OUT_MIN[OUT_WIDTH-1:0];
            rnd_clamp = 1'b1;
        end
    end

    logic                        snap_vld;
    logic signed [OUT_WIDTH-1:0] snap_data;
    logic                        snap_sat;
    logic [CNT_WIDTH-1:0]        snap_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_vld  <= 1'b0;
            snap_data <= '0;
            snap_sat  <= 1'b0;
            snap_len  <= '0;
        end else begin
            snap_vld <= done;
            if (done) begin
                snap_data <= rnd_out;
                snap_sat  <= rnd_clamp | acc_ovf;
                snap_len  <= cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_len   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (snap_vld) begin
                out_valid <= 1'b1;
                out_data  <= snap_data;
                out_sat   <= snap_sat;
                out_len   <= snap_len;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_dot_accum.sv
// Checks dsp_dot_accum with a vector table, hand-written corner sequences and a random run against a sum-based model.
module tb_dsp_dot_accum;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;
    logic signed [43:0] in_data;

    logic               a_valid, a_sat, a_ovr;
    logic signed [23:0] a_data;
    logic [15:0]        a_len;

    logic               b_valid, b_sat, b_ovr;
    logic signed [44:0] b_data;
    logic [2:0]         b_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_dot_accum u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data), .out_sat(a_sat),
        .out_len(a_len), .overrun(a_ovr)
    );

    dsp_dot_accum #(.ACC_WIDTH(45), .SHIFT(0), .OUT_WIDTH(45), .CNT_WIDTH(3)) u_acc45 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data), .out_sat(b_sat),
        .out_len(b_len), .overrun(b_ovr)
    );

    // Reference model: per instance, running vector sum and a two-deep result delay line.
    int     P_AW[2] = '{52, 45};
    int     P_SH[2] = '{4, 0};
    int     P_OW[2] = '{24, 45};
    int     P_CW[2] = '{16, 3};
    longint m_acc[2];
    int     m_cnt[2];
    bit     m_first[2], m_ovf[2];
    bit     s1v[2], s2v[2], s1s[2], s2s[2];
    longint s1d[2], s2d[2];
    int     s1l[2], s2l[2];
    bit     mv[2], ms[2], mo[2];
    longint md[2];
    int     ml[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_first[i] = 1; m_ovf[i] = 0;
            s1v[i] = 0; s2v[i] = 0; s1s[i] = 0; s2s[i] = 0;
            s1d[i] = 0; s2d[i] = 0; s1l[i] = 0; s2l[i] = 0;
            mv[i] = 0; ms[i] = 0; mo[i] = 0; md[i] = 0; ml[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit v, input longint d, input bit l, input bit rdy);
        longint amax, amin, omax, omin, sum, r;
        int     cmax, cnt;
        bit     ovf, clamp;
        if (s2v[i]) begin
            if (mv[i] && !rdy) mo[i] = 1;
            mv[i] = 1; md[i] = s2d[i]; ms[i] = s2s[i]; ml[i] = s2l[i];
        end else if (mv[i] && rdy) begin
            mv[i] = 0;
        end
        s2v[i] = s1v[i]; s2d[i] = s1d[i]; s2s[i] = s1s[i]; s2l[i] = s1l[i];
        s1v[i] = 0;
        if (v) begin
            amax = (longint'(1) <<< (P_AW[i] - 1)) - 1;
            amin = -amax - 1;
            cmax = (1 << P_CW[i]) - 1;
            sum  = (m_first[i] ? 0 : m_acc[i]) + d;
            ovf  = m_first[i] ? 1'b0 : m_ovf[i];
            cnt  = m_first[i] ? 1 : ((m_cnt[i] < cmax) ? m_cnt[i] + 1 : cmax);
            if (sum > amax) begin
                sum = amax; ovf = 1;
            end else if (sum < amin) begin
                sum = amin; ovf = 1;
            end
            m_acc[i] = sum; m_ovf[i] = ovf; m_cnt[i] = cnt; m_first[i] = l;
            if (l) begin
                r     = (sum + ((longint'(1) <<< P_SH[i]) >>> 1)) >>> P_SH[i];
                omax  = (longint'(1) <<< (P_OW[i] - 1)) - 1;
                omin  = -omax - 1;
                clamp = 0;
                if (r > omax) begin
                    r = omax; clamp = 1;
                end else if (r < omin) begin
                    r = omin; clamp = 1;
                end
                s1v[i] = 1; s1d[i] = r; s1s[i] = clamp | ovf; s1l[i] = cnt;
            end
        end
    endtask

    task automatic step(input bit v, input longint d, input bit l, input bit rdy);
        in_valid  = v;
        in_data   = d[43:0];
        in_last   = l;
        out_ready = rdy;
        @(posedge clk);
        if (!rst) begin
            model_edge(0, v, d, l, rdy);
            model_edge(1, v, d, l, rdy);
        end
        #1;
    endtask

    task automatic get_out(input int inst, output logic v, output longint d, output logic s,
                           output int len, output logic o);
        if (inst == 0) begin
            v = a_valid; d = longint'(a_data); s = a_sat; len = int'(a_len); o = a_ovr;
        end else begin
            v = b_valid; d = longint'(b_data); s = b_sat; len = int'(b_len); o = b_ovr;
        end
    endtask

    task automatic expect_out(input int inst, input string tag, input bit ev, input longint ed,
                              input bit es, input int el, input bit eo, input bit full);
        logic   v, s, o;
        longint d;
        int     len;
        bit     bad;
        get_out(inst, v, d, s, len, o);
        checks++;
        bad = (v !== ev) || (o !== eo);
        if (ev || full) bad = bad || (d != ed) || (s !== es) || (len != el);
        if (bad) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got v=%0b d=%0d sat=%0b len=%0d ovr=%0b, want v=%0b d=%0d sat=%0b len=%0d ovr=%0b",
                     tag, inst, $time, v, d, s, len, o, ev, ed, es, el, eo);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        expect_out(0, "reset", 0, 0, 0, 0, 0, 1);
        expect_out(1, "reset", 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit     v;
        longint d;
        bit     l;
        bit     rdy;
        bit     ev;
        longint ed;
        bit     es;
        int     el;
        bit     eo;
    } vec_t;

    function automatic vec_t mk(bit v, longint d, bit l, bit rdy, bit ev, longint ed, bit es, int el, bit eo);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.rdy = rdy;
        t.ev = ev; t.ed = ed; t.es = es; t.el = el; t.eo = eo;
        return t;
    endfunction

    initial begin
        vec_t   tbl[$];
        longint p40, p43;
        longint x, d;
        bit     v, l, rdy;

        p40 = longint'(1) <<< 40;
        p43 = longint'(1) <<< 43;

        // Basic vector, then length-1 rounding pair, output clamps, and backpressure overwrite.
        tbl.push_back(mk(1, 100, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 200, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, -50, 1, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 1,  1, 16, 0, 3, 0));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, -24, 1, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, -8,  1, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 1,  1, -1, 0, 1, 0));
        tbl.push_back(mk(0, 0,   0, 1,  1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, p40, 1, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, -p40, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 1,  1, 8388607, 1, 1, 0));
        tbl.push_back(mk(0, 0,   0, 1,  1, -8388608, 1, 1, 0));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7,   1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9,   1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,   0, 0,  1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0,   0, 0,  1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0,   0, 0,  1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,   0, 1,  0, 0, 0, 0, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy);
            expect_out(0, $sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].el, tbl[i].eo, 0);
        end

        // Reset mid-vector drops the partial sum and the sticky overrun.
        step(1, 32, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out(0, "pre_rst_result", 1, 2, 0, 1, 1, 0);
        step(1, 1000, 0, 0);
        step(1, 1000, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        expect_out(0, "async_rst", 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        expect_out(0, "in_rst", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        model_reset();
        step(1, 32, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out(0, "post_rst_vec", 1, 2, 0, 1, 0, 0);

        // Accumulator overflow on the 45-bit instance, recovery, and length saturation.
        do_reset();
        step(1, p43 - 1, 0, 1);
        step(1, p43 - 1, 0, 1);
        step(1, p43 - 1, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out(1, "acc_ovf_pos", 1, (longint'(1) <<< 44) - 1, 1, 3, 0, 0);
        step(1, 5, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out(1, "acc_ovf_clear", 1, 5, 0, 1, 0, 0);
        step(1, -p43, 0, 1);
        step(1, -p43, 0, 1);
        step(0, 0, 0, 1);
        step(1, -p43, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out(1, "acc_ovf_neg", 1, -(longint'(1) <<< 44), 1, 3, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, (i == 8), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out(1, "len_sat", 1, 9, 0, 7, 0, 0);

        // Random traffic against the model on both instances.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            l   = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: begin
                    x = {$urandom, $urandom};
                    d = (x <<< 20) >>> 20;
                end
                1: d = longint'($urandom_range(0, 8191)) - 4096;
                2: d = ($urandom_range(0, 1) == 1 ? 1 : -1) * (p43 - 1 - longint'($urandom_range(0, 1000)));
                default: d = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
            endcase
            step(v, d, l, rdy);
            expect_out(0, "random", mv[0], md[0], ms[0], ml[0], mo[0], 0);
            expect_out(1, "random", mv[1], md[1], ms[1], ml[1], mo[1], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
